// File: rtl/alu_issue_stage.sv
// Operand-fetch / write-back stage wrapped around the combinational 8-bit ALU.
// Owns the register file and NZCV status; one instruction per IDLE->EXEC->WB pass.
module alu_issue_stage #(
    parameter int DATA_W     = 8,
    parameter int REG_COUNT  = 8,
    parameter int REG_ADDR_W = 3,
    parameter int OP_W       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [OP_W-1:0]       instr_op,
    input  logic [REG_ADDR_W-1:0] instr_rd,
    input  logic [REG_ADDR_W-1:0] instr_rs1,
    input  logic [REG_ADDR_W-1:0] instr_rs2,
    input  logic                  instr_imm_en,
    input  logic [DATA_W-1:0]     instr_imm,
    input  logic                  instr_we,
    output logic [DATA_W-1:0]     A,
    output logic [DATA_W-1:0]     B,
    output logic [OP_W-1:0]       OP_Code,
    input  logic [DATA_W-1:0]     ALU_Result,
    input  logic [3:0]            ALU_NZCV,
    output logic [3:0]            NZCV_reg,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    input  logic [REG_ADDR_W-1:0] dbg_raddr,
    output logic [DATA_W-1:0]     dbg_rdata
);

    // Handshake: an instruction is taken on a rising edge where instr_valid and
    // instr_ready are both high; instr_ready is high only in IDLE and never during reset.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       a_q, a_d;
    logic [DATA_W-1:0]       b_q, b_d;
    logic [OP_W-1:0]         op_q, op_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic                    we_q, we_d;
    logic [3:0]              nzcv_q, nzcv_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]       wb_data_q, wb_data_d;
    logic [DATA_W-1:0]       regs_q [REG_COUNT];
    logic [DATA_W-1:0]       regs_d [REG_COUNT];
    logic                    accept;

    assign instr_ready = (state_q == ST_IDLE) && !rst;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        rd_d       = rd_q;
        we_d       = we_q;
        nzcv_d     = nzcv_q;
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        regs_d     = regs_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = regs_q[instr_rs1];
                    b_d     = instr_imm_en ? instr_imm : regs_q[instr_rs2];
                    op_d    = instr_op;
                    rd_d    = instr_rd;
                    we_d    = instr_we;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // The ALU has had a full cycle to settle on the registered operands.
                nzcv_d     = ALU_NZCV;
                wb_rd_d    = rd_q;
                wb_data_d  = ALU_Result;
                wb_valid_d = we_q;
                if (we_q) begin
                    regs_d[rd_q] = ALU_Result;
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                wb_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                wb_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            nzcv_q     <= 4'b0000;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            nzcv_q     <= nzcv_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            regs_q     <= regs_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign OP_Code   = op_q;
    assign NZCV_reg  = nzcv_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign dbg_rdata = regs_q[dbg_raddr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: ALU stub plus architectural register/flag model,
// directed steps followed by random instructions and a reset taken mid-instruction.
module tb_alu_issue_stage;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [2:0] instr_rd;
    logic [2:0] instr_rs1;
    logic [2:0] instr_rs2;
    logic       instr_imm_en;
    logic [7:0] instr_imm;
    logic       instr_we;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] OP_Code;
    logic [7:0] alu_result;
    logic [3:0] alu_nzcv;
    logic [3:0] NZCV_reg;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic [2:0] dbg_raddr;
    logic [7:0] dbg_rdata;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] m_regs [8];
    logic [3:0] m_nzcv;

    alu_issue_stage dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_rs1    (instr_rs1),
        .instr_rs2    (instr_rs2),
        .instr_imm_en (instr_imm_en),
        .instr_imm    (instr_imm),
        .instr_we     (instr_we),
        .A            (A),
        .B            (B),
        .OP_Code      (OP_Code),
        .ALU_Result   (alu_result),
        .ALU_NZCV     (alu_nzcv),
        .NZCV_reg     (NZCV_reg),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .dbg_raddr    (dbg_raddr),
        .dbg_rdata    (dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU behaviour: returns {N,Z,C,V,result}. Op 0 is ADD; C on SUB means no borrow.
    function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] res;
        logic       c;
        logic       v;
        s = 9'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                s   = {1'b0, a} + {1'b0, b};
                res = s[7:0];
                c   = s[8];
                v   = (a[7] == b[7]) && (res[7] != a[7]);
            end
            3'd1: begin
                s   = {1'b0, a} - {1'b0, b};
                res = s[7:0];
                c   = ~s[8];
                v   = (a[7] != b[7]) && (res[7] != a[7]);
            end
            3'd2:    res = a & b;
            3'd3:    res = a | b;
            3'd4:    res = a ^ b;
            default: res = b;
        endcase
        return {res[7], (res == 8'h00), c, v, res};
    endfunction

    assign {alu_nzcv, alu_result} = alu_ref(OP_Code, A, B);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input string tag, input logic [2:0] idx, input logic [7:0] exp);
        dbg_raddr = idx;
        #1;
        check(tag, {24'd0, dbg_rdata}, {24'd0, exp});
    endtask

    // Issue one instruction from IDLE and follow it through EXEC and WB.
    // hold keeps instr_valid high afterwards; noise wiggles the inputs during EXEC/WB.
    task automatic do_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic imm_en, input logic [7:0] imm,
                            input logic we, input bit hold, input bit noise);
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [11:0] r;
        @(negedge clk);
        instr_valid  = 1'b1;
        instr_op     = op;
        instr_rd     = rd;
        instr_rs1    = rs1;
        instr_rs2    = rs2;
        instr_imm_en = imm_en;
        instr_imm    = imm;
        instr_we     = we;
        #1;
        check("ready_idle", {31'd0, instr_ready}, 32'd1);
        ea = m_regs[rs1];
        eb = imm_en ? imm : m_regs[rs2];
        r  = alu_ref(op, ea, eb);
        @(posedge clk);
        #1;
        check("a_latched", {24'd0, A}, {24'd0, ea});
        check("b_latched", {24'd0, B}, {24'd0, eb});
        check("op_latched", {29'd0, OP_Code}, {29'd0, op});
        check("ready_exec", {31'd0, instr_ready}, 32'd0);
        check("wbv_exec", {31'd0, wb_valid}, 32'd0);
        if (!hold) instr_valid = 1'b0;
        if (noise) begin
            instr_valid  = 1'b1;
            instr_rs1    = 3'($urandom_range(0, 7));
            instr_rs2    = 3'($urandom_range(0, 7));
            instr_op     = 3'($urandom_range(0, 7));
            instr_imm_en = 1'b1;
            instr_imm    = 8'($urandom_range(0, 255));
        end
        @(posedge clk);
        #1;
        check("wbv_wb", {31'd0, wb_valid}, {31'd0, we});
        if (we) begin
            check("wb_rd", {29'd0, wb_rd}, {29'd0, rd});
            check("wb_data", {24'd0, wb_data}, {24'd0, r[7:0]});
            m_regs[rd] = r[7:0];
        end
        m_nzcv = r[11:8];
        check("nzcv", {28'd0, NZCV_reg}, {28'd0, m_nzcv});
        check("ready_wb", {31'd0, instr_ready}, 32'd0);
        read_reg("dbg_rd", rd, m_regs[rd]);
        @(posedge clk);
        #1;
        check("wbv_done", {31'd0, wb_valid}, 32'd0);
        check("ready_back", {31'd0, instr_ready}, 32'd1);
        check("a_hold", {24'd0, A}, {24'd0, ea});
        if (noise) begin
            instr_valid = 1'b0;
            @(posedge clk);
            #1;
            check("noise_ready", {31'd0, instr_ready}, 32'd1);
            check("noise_a", {24'd0, A}, {24'd0, ea});
            check("noise_b", {24'd0, B}, {24'd0, eb});
            check("noise_op", {29'd0, OP_Code}, {29'd0, op});
        end
    endtask

    task automatic do_random();
        do_instr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) != 0), 1'b0, 1'($urandom_range(0, 4) == 0));
    endtask

    initial begin
        rst          = 1'b1;
        instr_valid  = 1'b0;
        instr_op     = 3'd0;
        instr_rd     = 3'd0;
        instr_rs1    = 3'd0;
        instr_rs2    = 3'd0;
        instr_imm_en = 1'b0;
        instr_imm    = 8'd0;
        instr_we     = 1'b0;
        dbg_raddr    = 3'd0;
        m_nzcv       = 4'b0000;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_wbv", {31'd0, wb_valid}, 32'd0);
        check("rst_nzcv", {28'd0, NZCV_reg}, 32'd0);
        check("rst_a", {24'd0, A}, 32'd0);
        check("rst_b", {24'd0, B}, 32'd0);
        check("rst_op", {29'd0, OP_Code}, 32'd0);
        for (int i = 0; i < 8; i++) read_reg("rst_reg", 3'(i), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, instr_ready}, 32'd1);

        // R1 = R0 + 5
        do_instr(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
        read_reg("r1_05", 3'd1, 8'h05);
        check("nzcv_0000", {28'd0, NZCV_reg}, 32'h0);

        // R2 = R1 + R1 twice with instr_valid held high between them
        do_instr(3'd0, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        do_instr(3'd0, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        read_reg("r2_0a", 3'd2, 8'h0A);

        // Signed overflow: 7F + 01
        do_instr(3'd0, 3'd3, 3'd0, 3'd0, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0);
        do_instr(3'd0, 3'd4, 3'd3, 3'd0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        read_reg("r4_80", 3'd4, 8'h80);
        check("nzcv_1001", {28'd0, NZCV_reg}, 32'h9);

        // Compare-style (we=0): FF + 01 sets Z and C, R5 stays FF
        do_instr(3'd0, 3'd5, 3'd0, 3'd0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        do_instr(3'd0, 3'd5, 3'd5, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        read_reg("r5_ff", 3'd5, 8'hFF);
        check("nzcv_0110", {28'd0, NZCV_reg}, 32'h6);

        // Input activity during EXEC/WB must be ignored
        do_instr(3'd4, 3'd6, 3'd1, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        read_reg("r6_xor", 3'd6, 8'h0F);

        // rd == rs1 uses the pre-write operand
        do_instr(3'd0, 3'd1, 3'd1, 3'd1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        read_reg("r1_0a", 3'd1, 8'h0A);

        for (int n = 0; n < 40; n++) do_random();
        for (int i = 0; i < 8; i++) read_reg("rand_reg", 3'(i), m_regs[i]);

        // Reset arriving while an instruction is in EXEC
        @(negedge clk);
        instr_valid  = 1'b1;
        instr_op     = 3'd0;
        instr_rd     = 3'd7;
        instr_rs1    = 3'd0;
        instr_imm_en = 1'b1;
        instr_imm    = 8'h33;
        instr_we     = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check("mid_exec_ready", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, instr_ready}, 32'd0);
        check("mid_rst_wbv", {31'd0, wb_valid}, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("mid_rst_wbv_hold", {31'd0, wb_valid}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_nzcv = 4'b0000;
        @(posedge clk);
        #1;
        check("post_rst_ready", {31'd0, instr_ready}, 32'd1);
        check("post_rst_wbv", {31'd0, wb_valid}, 32'd0);
        check("post_rst_nzcv", {28'd0, NZCV_reg}, 32'h0);
        for (int i = 0; i < 8; i++) read_reg("post_rst_reg", 3'(i), 8'h00);

        for (int n = 0; n < 10; n++) do_random();
        for (int i = 0; i < 8; i++) read_reg("final_reg", 3'(i), m_regs[i]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
